// File: rtl/pcie_ep_pkg.sv
// Shared constants and types for the multi-function endpoint:
// request field positions, completion status codes and config map.
package pcie_ep_pkg;

    localparam int TLP_CFG      = 31;
    localparam int TLP_WR       = 30;
    localparam int TLP_FUNC_HI  = 29;
    localparam int TLP_FUNC_LO  = 28;
    localparam int TLP_TAG_HI   = 27;
    localparam int TLP_TAG_LO   = 24;
    localparam int TLP_ADDR_HI  = 23;
    localparam int TLP_ADDR_LO  = 16;
    localparam int TLP_WDATA_HI = 15;
    localparam int TLP_WDATA_LO = 0;

    localparam int MAX_FUNC = 4;

    typedef enum logic [1:0] {
        ST_SC = 2'b00,
        ST_UR = 2'b01
    } status_e;

    localparam logic [7:0] CFG_ID   = 8'h00;
    localparam logic [7:0] CFG_CMD  = 8'h04;
    localparam logic [7:0] CFG_BAR0 = 8'h10;

    localparam logic [31:0] WR_ACK = 32'h0000_0001;

    typedef struct packed {
        logic [31:0] data;
        status_e     status;
        logic [1:0]  func;
        logic [3:0]  tag;
    } rsp_t;

    function automatic logic [31:0] cfg_id(
        input logic [31:0] base,
        input logic [1:0]  func
    );
        return base ^ {30'b0, func};
    endfunction

endpackage

// File: rtl/pcie_ep_rsp_fifo.sv
// Completion queue: circular buffer with a registered occupancy count,
// valid/ready on both sides; full and empty gate the handshakes.
module pcie_ep_rsp_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_cnt < CW'(DEPTH));
    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage is not reset; the head is only observed while o_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/pcie_endpoint_mf.sv
// Multi-function endpoint: decodes config/memory requests, executes
// them at the accepting edge and queues one completion per request.
module pcie_endpoint_mf
    import pcie_ep_pkg::*;
#(
    parameter int          NUM_FUNC   = 2,
    parameter int          MEM_DEPTH  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] DEVICE_ID  = 32'h12345678
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tlp_data,
    input  logic        tlp_valid,
    output logic        tlp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic [1:0]  rsp_func,
    output logic [3:0]  rsp_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  err_count
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [15:0] r_mem [MEM_DEPTH];
    logic [15:0] r_cmd [MAX_FUNC];
    logic [15:0] r_bar [MAX_FUNC];
    logic [7:0]  r_err;

    logic        w_accept;
    logic        w_cfg;
    logic        w_wr;
    logic [1:0]  w_func;
    logic [3:0]  w_tag;
    logic [7:0]  w_addr;
    logic [15:0] w_wdata;
    logic        w_ur;
    logic [31:0] w_data;
    logic        w_cmd_we;
    logic        w_bar_we;
    logic        w_mem_we;
    rsp_t        w_push;
    rsp_t        w_head;

    assign w_cfg   = tlp_data[TLP_CFG];
    assign w_wr    = tlp_data[TLP_WR];
    assign w_func  = tlp_data[TLP_FUNC_HI:TLP_FUNC_LO];
    assign w_tag   = tlp_data[TLP_TAG_HI:TLP_TAG_LO];
    assign w_addr  = tlp_data[TLP_ADDR_HI:TLP_ADDR_LO];
    assign w_wdata = tlp_data[TLP_WDATA_HI:TLP_WDATA_LO];
    assign w_accept = tlp_valid && tlp_ready;

    always_comb begin
        w_ur     = 1'b0;
        w_data   = '0;
        w_cmd_we = 1'b0;
        w_bar_we = 1'b0;
        w_mem_we = 1'b0;
        if (int'(w_func) >= NUM_FUNC) begin
            w_ur = 1'b1;
        end else if (w_cfg) begin
            unique case (w_addr)
                CFG_ID: begin
                    if (w_wr) w_ur = 1'b1;
                    else      w_data = cfg_id(DEVICE_ID, w_func);
                end
                CFG_CMD: begin
                    w_cmd_we = w_wr;
                    w_data   = w_wr ? WR_ACK : {16'b0, r_cmd[w_func]};
                end
                CFG_BAR0: begin
                    w_bar_we = w_wr;
                    w_data   = w_wr ? WR_ACK : {16'b0, r_bar[w_func]};
                end
                default: w_ur = 1'b1;
            endcase
        end else if (int'(w_addr) >= MEM_DEPTH || !r_cmd[w_func][0]) begin
            w_ur = 1'b1;
        end else begin
            w_mem_we = w_wr;
            w_data   = w_wr ? WR_ACK : {16'b0, r_mem[w_addr[AW-1:0]]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_FUNC; i++) begin
                r_cmd[i] <= '0;
                r_bar[i] <= '0;
            end
            r_err <= '0;
        end else if (w_accept) begin
            if (w_cmd_we) r_cmd[w_func] <= w_wdata;
            if (w_bar_we) r_bar[w_func] <= w_wdata;
            if (w_ur && r_err != 8'hFF) r_err <= r_err + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_mem_we) r_mem[w_addr[AW-1:0]] <= w_wdata;
    end

    assign w_push.data   = w_data;
    assign w_push.status = w_ur ? ST_UR : ST_SC;
    assign w_push.func   = w_func;
    assign w_push.tag    = w_tag;

    pcie_ep_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (w_push),
        .i_valid (tlp_valid),
        .o_ready (tlp_ready),
        .o_data  (w_head),
        .o_valid (rsp_valid),
        .i_ready (rsp_ready)
    );

    // Head fields read zero while the queue is empty.
    assign rsp_data   = rsp_valid ? w_head.data   : '0;
    assign rsp_status = rsp_valid ? w_head.status : ST_SC;
    assign rsp_func   = rsp_valid ? w_head.func   : '0;
    assign rsp_tag    = rsp_valid ? w_head.tag    : '0;
    assign err_count  = r_err;

endmodule

// File: tb/tb_pcie_endpoint_mf.sv
// Directed bench for pcie_endpoint_mf: a vector table of single
// requests plus backpressure and mid-operation reset sequences.
module tb_pcie_endpoint_mf;

    logic        clk;
    logic        rst_n;
    logic [31:0] tlp_data;
    logic        tlp_valid;
    logic        tlp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [1:0]  rsp_func;
    logic [3:0]  rsp_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  err_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] tlp;
        logic [31:0] data;
        logic [1:0]  st;
        logic [7:0]  err;
    } vec_t;

    localparam logic [1:0] SC = 2'b00;
    localparam logic [1:0] UR = 2'b01;

    pcie_endpoint_mf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tlp_data   (tlp_data),
        .tlp_valid  (tlp_valid),
        .tlp_ready  (tlp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .rsp_func   (rsp_func),
        .rsp_tag    (rsp_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(
        input logic cfg, input logic wr, input logic [1:0] func,
        input logic [3:0] tag, input logic [7:0] addr,
        input logic [15:0] wdata
    );
        return {cfg, wr, func, tag, addr, wdata};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with rsp_ready high; one request, one completion.
    task automatic run_vec(input string nm, input vec_t v);
        chk({nm, " ready"}, 32'(tlp_ready), 32'd1);
        tlp_data  = v.tlp;
        tlp_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tlp_valid = 1'b0;
        tlp_data  = $urandom;
        chk({nm, " valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, " data"}, rsp_data, v.data);
        chk({nm, " status"}, 32'(rsp_status), 32'(v.st));
        chk({nm, " tag"}, 32'(rsp_tag), 32'(v.tlp[27:24]));
        chk({nm, " func"}, 32'(rsp_func), 32'(v.tlp[29:28]));
        chk({nm, " err"}, 32'(err_count), 32'(v.err));
    endtask

    task automatic send_only(input logic [31:0] t);
        tlp_data  = t;
        tlp_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tlp_valid = 1'b0;
    endtask

    vec_t tv [18];
    vec_t rv;
    int   got;
    int   exp_tag;
    logic sent5;

    initial begin
        tv[0]  = '{mk(1,0,1,3,8'h00,16'h0),    32'h12345679, SC, 8'd0};
        tv[1]  = '{mk(1,1,0,1,8'h10,16'h1234), 32'h00000001, SC, 8'd0};
        tv[2]  = '{mk(1,0,0,2,8'h10,16'h0),    32'h00001234, SC, 8'd0};
        tv[3]  = '{mk(1,0,1,4,8'h10,16'h0),    32'h00000000, SC, 8'd0};
        tv[4]  = '{mk(0,1,0,5,8'h02,16'h5678), 32'h00000000, UR, 8'd1};
        tv[5]  = '{mk(1,1,0,6,8'h04,16'h0001), 32'h00000001, SC, 8'd1};
        tv[6]  = '{mk(0,1,0,7,8'h02,16'h5678), 32'h00000001, SC, 8'd1};
        tv[7]  = '{mk(0,0,0,8,8'h02,16'h0),    32'h00005678, SC, 8'd1};
        tv[8]  = '{mk(1,0,0,9,8'h04,16'h0),    32'h00000001, SC, 8'd1};
        tv[9]  = '{mk(1,0,3,9,8'h00,16'h0),    32'h00000000, UR, 8'd2};
        tv[10] = '{mk(0,0,0,10,8'h80,16'h0),   32'h00000000, UR, 8'd3};
        tv[11] = '{mk(1,1,0,11,8'h00,16'hFFFF),32'h00000000, UR, 8'd4};
        tv[12] = '{mk(1,0,0,12,8'h08,16'h0),   32'h00000000, UR, 8'd5};
        tv[13] = '{mk(0,0,1,13,8'h02,16'h0),   32'h00000000, UR, 8'd6};
        tv[14] = '{mk(1,0,0,14,8'h00,16'h0),   32'h12345678, SC, 8'd6};
        tv[15] = '{mk(0,1,0,15,8'h3F,16'hBEEF),32'h00000001, SC, 8'd6};
        tv[16] = '{mk(0,0,0,0,8'h3F,16'h0),    32'h0000BEEF, SC, 8'd6};
        tv[17] = '{mk(0,0,0,1,8'h40,16'h0),    32'h00000000, UR, 8'd7};

        rst_n     = 1'b0;
        tlp_valid = 1'b0;
        tlp_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst valid", 32'(rsp_valid), 32'd0);
        chk("rst data", rsp_data, 32'd0);
        chk("rst err", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst ready", 32'(tlp_ready), 32'd1);
        chk("rst tag", 32'(rsp_tag), 32'd0);
        chk("rst status", 32'(rsp_status), 32'd0);

        for (int i = 0; i < 18; i++)
            run_vec($sformatf("v%0d", i), tv[i]);
        @(negedge clk);
        chk("drained", 32'(rsp_valid), 32'd0);

        // Fill the queue under backpressure, then drain in order.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_only(mk(1,0,0,4'(i),8'h00,16'h0));
        chk("full ready", 32'(tlp_ready), 32'd0);
        chk("full head tag", 32'(rsp_tag), 32'd0);
        tlp_data  = mk(1,0,0,4,8'h00,16'h0);
        tlp_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("stall ready", 32'(tlp_ready), 32'd0);
        chk("stall tag", 32'(rsp_tag), 32'd0);
        chk("stall data", rsp_data, 32'h12345678);
        rsp_ready = 1'b1;
        got     = 0;
        exp_tag = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (rsp_valid) begin
                chk($sformatf("drain tag%0d", exp_tag),
                    32'(rsp_tag), 32'(exp_tag));
                exp_tag++;
                got++;
            end
            sent5 = tlp_valid && tlp_ready;
            @(posedge clk);
            @(negedge clk);
            if (sent5) tlp_valid = 1'b0;
        end
        chk("drain count", 32'(got), 32'd5);
        chk("drain sent", 32'(tlp_valid), 32'd0);

        // Reset with three queued completions.
        rsp_ready = 1'b0;
        send_only(mk(1,1,1,1,8'h10,16'hABCD));
        send_only(mk(1,1,1,2,8'h04,16'h0001));
        send_only(mk(1,0,0,3,8'h00,16'h0));
        chk("q3 valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async valid", 32'(rsp_valid), 32'd0);
        chk("async err", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        rv = '{mk(1,0,1,5,8'h10,16'h0), 32'h0, SC, 8'd0};
        run_vec("post bar1", rv);
        rv = '{mk(1,0,1,6,8'h04,16'h0), 32'h0, SC, 8'd0};
        run_vec("post cmd1", rv);
        rv = '{mk(1,0,0,7,8'h04,16'h0), 32'h0, SC, 8'd0};
        run_vec("post cmd0", rv);
        rv = '{mk(0,0,0,8,8'h02,16'h0), 32'h0, UR, 8'd1};
        run_vec("post mem", rv);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
